icu_biu_responder: RTL

- BIU-side responder for the instruction-cache refill interface.
- Accepts line-fill or single-beat requests from the ICU and issues one 64-bit read at a time to a simple memory port.
- Returns beats to the ICU with valid, last and fault flags.
- Sits between the ICU and the memory/bus fabric, and replaces the bench-driven BIU model used today.

---
 rtl/icu_biu_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/icu_biu_responder.sv
`timescale 1ns/1ps
// icu_biu_responder
//   BIU-side responder for instruction-cache refills. It accepts one request
//   from the ICU at a time, either a single beat or a BEATS-beat wrapping line
//   burst that starts at the critical beat. It issues one 64-bit read at a time
//   to the memory port and returns each beat to the ICU with valid/last/fault.
//   A bus error or a read timeout returns a fault beat and ends the transaction.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   icu_biu_req/addr/single  refill request (addr is byte address [31:3])
//   biu_icu_ack           one-cycle acceptance pulse
//   biu_icu_data_valid/last/data/fault  returned beat (no backpressure)
//   biu_mem_req/addr      memory read request, held until mem_biu_gnt
//   mem_biu_gnt           read accepted
//   mem_biu_rvalid/rdata/err  read return, one per grant, in order
module icu_biu_responder #(
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icu_biu_req,
  input  logic [28:0] icu_biu_addr,
  input  logic        icu_biu_single,
  output logic        biu_icu_ack,
  output logic        biu_icu_data_valid,
  output logic        biu_icu_data_last,
  output logic [63:0] biu_icu_data,
  output logic        biu_icu_fault,
  output logic        biu_mem_req,
  output logic [28:0] biu_mem_addr,
  input  logic        mem_biu_gnt,
  input  logic        mem_biu_rvalid,
  input  logic [63:0] mem_biu_rdata,
  input  logic        mem_biu_err
);

  localparam int LB = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LB-1:0] LAST_IDX = LB'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [28:0]   addr_q, addr_d;
  logic          single_q, single_d;
  logic [LB-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0]   data_q, data_d;
  logic          fault_q, fault_d;
  logic          last_w;
  logic          active;

  // Only the low LB address bits advance, so the burst wraps inside the line.
  function automatic logic [28:0] beat_addr(input logic [28:0] base,
                                            input logic [LB-1:0] idx);
    logic [LB-1:0] low;
    low = base[LB-1:0] + idx;
    return {base[28:LB], low};
  endfunction

  // Control state: cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      single_q <= 1'b0;
      idx_q    <= '0;
      tmo_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      fault_q  <= fault_d;
    end
  end

  // Datapath registers: only observed through the valid-gated outputs.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign last_w = fault_q | single_q | (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    single_d = single_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    fault_d  = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (icu_biu_req) begin
          addr_d   = icu_biu_addr;
          single_d = icu_biu_single;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        idx_d   = '0;
        fault_d = 1'b0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_biu_gnt) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_biu_rvalid) begin
          data_d  = mem_biu_rdata;
          fault_d = mem_biu_err;
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          // The outstanding read is abandoned; any late rvalid lands in IDLE.
          data_d  = '0;
          fault_d = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (last_w) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state and forced low while reset is held, so
  // they are quiet even in the first reset cycle of an abandoned transaction.
  assign active             = ~reset;
  assign biu_icu_ack        = active & (state_q == S_ACK);
  assign biu_mem_req        = active & (state_q == S_REQ);
  assign biu_mem_addr       = biu_mem_req ? beat_addr(addr_q, idx_q) : '0;
  assign biu_icu_data_valid = active & (state_q == S_RESP);
  assign biu_icu_data_last  = biu_icu_data_valid & last_w;
  assign biu_icu_fault      = biu_icu_data_valid & fault_q;
  assign biu_icu_data       = biu_icu_data_valid ? data_q : '0;

endmodule
